attack_engine: RTL and testbench
================================

ATTACK_ENGINE -- requirements
Module: attack_engine

Interface
REQ-001 SHALL have parameter KEY_P1, default 8'h06, meaning P1 attack keycode.
REQ-002 SHALL have parameter KEY_P2, default 8'h11, meaning P2 attack keycode.
REQ-003 SHALL have parameters STARTUP, ACTIVE, RECOVERY, defaults 2, 3, 4, meaning frames per attack phase, each >= 1.
REQ-004 SHALL have parameters HITSTUN, BLOCKSTUN, defaults 12, 6, meaning stun frames after a hit or a block.
REQ-005 SHALL have parameters REACH, FIST_OFS_P1, FIST_OFS_P2, defaults 135, 30, 60, meaning horizontal reach and fist height offsets.
REQ-006 SHALL have parameter KB_SPEED, default 4, meaning hit knockback magnitude in pixels per frame.
REQ-007 SHALL have parameter CW, default 8, meaning phase/stun counter width, with 2^CW > every frame parameter.
REQ-008 SHALL have port frame_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-009 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-010 SHALL have ports keycode_0..keycode_3, input, 8 bits each: currently held keys.
REQ-011 SHALL have ports crouchP1, crouchP2, input, 1 bit each: player is crouching/guarding.
REQ-012 SHALL have port P1Left, input, 1 bit: P1 is left of P2.
REQ-013 SHALL have ports XDist, P1Ypos, P2Ypos, input, 32-bit signed each: horizontal separation and vertical positions.
REQ-014 SHALL have ports activeP1, activeP2, output, 1 bit each: player is in the ACTIVE phase.
REQ-015 SHALL have ports hitP1, hitP2, blockP1, blockP2, output, 1 bit each: one-frame pulse, player took a hit or blocked.
REQ-016 SHALL have ports stunP1, stunP2, output, 1 bit each: stun counter nonzero.
REQ-017 SHALL have ports Ryu_Knockback, Akuma_Knockback, output, 32-bit signed each: per-frame X motion for P1 and P2.

Function
REQ-018 SHALL treat a player key as pressed when any keycode_n equals that player's key.
REQ-019 SHALL register pressed each frame; an attack trigger is a rising edge (pressed now, not pressed previous frame), so holding the key SHALL NOT retrigger.
REQ-020 SHALL run one FSM per player with states IDLE, STARTUP, ACTIVE, RECOVERY, each non-IDLE state lasting exactly its parameter in frames, then advancing IDLE->STARTUP->ACTIVE->RECOVERY->IDLE.
REQ-021 SHALL leave IDLE only on a trigger while not crouching and stun counter zero; a trigger in any other state or condition SHALL be discarded, not queued.
REQ-022 SHALL detect P1 connecting while P1 is in ACTIVE, its once-per-attack connected flag is clear, XDist < REACH (signed), and P1Ypos+FIST_OFS_P1 > P2Ypos; P2 mirrors this with FIST_OFS_P2 and P1Ypos.
REQ-023 SHALL, on the edge after a connect, set the attacker's connected flag, and SHALL pulse blockDefender and load BLOCKSTUN if the defender crouches, else pulse hitDefender and load HITSTUN.
REQ-024 SHALL force the defender's FSM to IDLE on that same edge when it is hit, but SHALL NOT change the defender's FSM when it blocks.
REQ-025 SHALL let a connect during nonzero stun reload the counter, with no saturation or accumulation.
REQ-026 SHALL apply a simultaneous connect by both players (trade) to both sides on the same edge.
REQ-027 SHALL decrement each stun counter by 1 per frame while it is nonzero.
REQ-028 SHALL drive knockback while stunned at magnitude KB_SPEED after a hit or KB_SPEED>>1 after a block, directed away from the opponent: P1 negative and P2 positive when P1Left=1, reversed otherwise; 0 when not stunned.
REQ-029 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, while Reset_n=0, asynchronously set both FSMs to IDLE and clear all counters, connected flags, and previous-pressed registers.
REQ-031 SHALL hold every output at 0 during reset, including when Reset_n is asserted mid-attack or mid-stun.
REQ-032 SHALL require a fresh key rising edge to start an attack after reset release.

Verification
REQ-033 SHALL verify the nominal hit: P1 key held, XDist=100, P1Ypos=P2Ypos=200, no crouch -> activeP1 high 3 frames after 2 startup frames; hitP2 pulses once; stunP2 high 12 frames; Akuma_Knockback=+4 (P1Left=1).
REQ-034 SHALL verify the block: as REQ-033 with crouchP2=1 -> blockP2 pulses, no hitP2, stunP2 high 6 frames, Akuma_Knockback=+2.
REQ-035 SHALL verify the out-of-reach miss: XDist=135 -> no hit or block, P1 returns to IDLE after 9 frames total.
REQ-036 SHALL verify the interrupt and trade: P2 hit during its STARTUP -> activeP2 never asserts; both ACTIVE and in range -> hitP1 and hitP2 pulse on the same frame.
REQ-037 SHALL verify trigger gating: key held 20 frames -> exactly one attack; key pressed while stunned or crouching -> no attack.
REQ-038 SHALL verify reset mid-stun: Reset_n=0 -> all outputs 0 immediately; after release, knockback stays 0.

Source files
------------

// File: rtl/attack_engine.sv
// Two-player attack engine: per-player attack phase FSM, hit/block
// resolution, stun countdown and knockback generation, one step per frame.
module attack_engine #(
  parameter logic [7:0] KEY_P1      = 8'h06,
  parameter logic [7:0] KEY_P2      = 8'h11,
  parameter int         STARTUP     = 2,
  parameter int         ACTIVE      = 3,
  parameter int         RECOVERY    = 4,
  parameter int         HITSTUN     = 12,
  parameter int         BLOCKSTUN   = 6,
  parameter int         REACH       = 135,
  parameter int         FIST_OFS_P1 = 30,
  parameter int         FIST_OFS_P2 = 60,
  parameter int         KB_SPEED    = 4,
  parameter int         CW          = 8
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic [7:0]         keycode_0,
  input  logic [7:0]         keycode_1,
  input  logic [7:0]         keycode_2,
  input  logic [7:0]         keycode_3,
  input  logic               crouchP1,
  input  logic               crouchP2,
  input  logic               P1Left,
  input  logic signed [31:0] XDist,
  input  logic signed [31:0] P1Ypos,
  input  logic signed [31:0] P2Ypos,
  output logic               activeP1,
  output logic               activeP2,
  output logic               hitP1,
  output logic               hitP2,
  output logic               blockP1,
  output logic               blockP2,
  output logic               stunP1,
  output logic               stunP2,
  output logic signed [31:0] Ryu_Knockback,
  output logic signed [31:0] Akuma_Knockback
);

  typedef enum logic [1:0] {ST_IDLE, ST_STARTUP, ST_ACTIVE, ST_RECOVERY} phase_t;

  // Index 0 is P1, index 1 is P2 throughout.
  logic [1:0]         connect;   // player's attack lands this frame
  logic [1:0]         crouch;
  logic               in_reach;
  logic signed [31:0] ypos [2];
  logic [1:0]         active_vec, hit_vec, block_vec, stun_vec;
  logic signed [31:0] kb_vec [2];

  assign crouch   = {crouchP2, crouchP1};
  assign in_reach = (XDist < REACH);
  assign ypos[0]  = P1Ypos;
  assign ypos[1]  = P2Ypos;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      localparam logic [7:0] KEY      = (gi == 0) ? KEY_P1 : KEY_P2;
      localparam int         FIST_OFS = (gi == 0) ? FIST_OFS_P1 : FIST_OFS_P2;
      localparam int         OPP      = 1 - gi;

      phase_t             state_reg, state_next;
      logic [CW-1:0]      phase_reg, phase_next;
      logic [CW-1:0]      stun_reg, stun_next;
      logic               conn_reg, conn_next;
      logic               kbhit_reg, kbhit_next;   // last stun came from a hit
      logic               prev_reg, pressed, trigger;
      logic               hit_reg, block_reg;
      logic               took_hit, took_block, away_neg;
      logic signed [31:0] kb_reg, kb_next, mag;

      assign pressed = (keycode_0 == KEY) || (keycode_1 == KEY) ||
                       (keycode_2 == KEY) || (keycode_3 == KEY);
      assign trigger = pressed && !prev_reg;

      // Only the first landing frame of an attack counts; the fist must reach
      // below the opponent's Y (screen Y grows downward).
      assign connect[gi] = (state_reg == ST_ACTIVE) && !conn_reg && in_reach &&
                           ((ypos[gi] + FIST_OFS) > ypos[OPP]);
      assign took_hit    = connect[OPP] && !crouch[gi];
      assign took_block  = connect[OPP] && crouch[gi];
      assign away_neg    = (gi == 0) ? P1Left : !P1Left;

      // Attack phase sequencing; being hit cancels whatever phase we were in.
      always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        conn_next  = conn_reg;
        case (state_reg)
          ST_IDLE: begin
            if (trigger && !crouch[gi] && (stun_reg == '0)) begin
              state_next = ST_STARTUP;
              phase_next = '0;
              conn_next  = 1'b0;
            end
          end
          ST_STARTUP: begin
            if (phase_reg == CW'(STARTUP - 1)) begin
              state_next = ST_ACTIVE;
              phase_next = '0;
            end else begin
              phase_next = phase_reg + CW'(1);
            end
          end
          ST_ACTIVE: begin
            if (connect[gi]) conn_next = 1'b1;
            if (phase_reg == CW'(ACTIVE - 1)) begin
              state_next = ST_RECOVERY;
              phase_next = '0;
            end else begin
              phase_next = phase_reg + CW'(1);
            end
          end
          ST_RECOVERY: begin
            if (phase_reg == CW'(RECOVERY - 1)) begin
              state_next = ST_IDLE;
              phase_next = '0;
            end else begin
              phase_next = phase_reg + CW'(1);
            end
          end
          default: begin
            state_next = ST_IDLE;
            phase_next = '0;
          end
        endcase
        if (took_hit) begin
          state_next = ST_IDLE;
          phase_next = '0;
        end
      end

      // Stun reload/countdown and the knockback that accompanies it.
      always_comb begin
        stun_next  = stun_reg;
        kbhit_next = kbhit_reg;
        kb_next    = '0;
        mag        = '0;
        if (took_hit) begin
          stun_next  = CW'(HITSTUN);
          kbhit_next = 1'b1;
        end else if (took_block) begin
          stun_next  = CW'(BLOCKSTUN);
          kbhit_next = 1'b0;
        end else if (stun_reg != '0) begin
          stun_next = stun_reg - CW'(1);
        end
        if (stun_next != '0) begin
          mag     = kbhit_next ? 32'(KB_SPEED) : 32'(KB_SPEED >> 1);
          kb_next = away_neg ? -mag : mag;
        end
      end

      // FSM state register.
      always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
          state_reg <= ST_IDLE;
          phase_reg <= '0;
          conn_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          phase_reg <= phase_next;
          conn_reg  <= conn_next;
        end
      end

      // Key history, stun state and registered hit/block/knockback outputs.
      always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
          prev_reg  <= 1'b0;
          stun_reg  <= '0;
          kbhit_reg <= 1'b0;
          hit_reg   <= 1'b0;
          block_reg <= 1'b0;
          kb_reg    <= '0;
        end else begin
          prev_reg  <= pressed;
          stun_reg  <= stun_next;
          kbhit_reg <= kbhit_next;
          hit_reg   <= took_hit;
          block_reg <= took_block;
          kb_reg    <= kb_next;
        end
      end

      assign active_vec[gi] = (state_reg == ST_ACTIVE);
      assign hit_vec[gi]    = hit_reg;
      assign block_vec[gi]  = block_reg;
      assign stun_vec[gi]   = (stun_reg != '0);
      assign kb_vec[gi]     = kb_reg;
    end
  endgenerate

  assign activeP1        = active_vec[0];
  assign activeP2        = active_vec[1];
  assign hitP1           = hit_vec[0];
  assign hitP2           = hit_vec[1];
  assign blockP1         = block_vec[0];
  assign blockP2         = block_vec[1];
  assign stunP1          = stun_vec[0];
  assign stunP2          = stun_vec[1];
  assign Ryu_Knockback   = kb_vec[0];
  assign Akuma_Knockback = kb_vec[1];

endmodule

// File: tb/tb_attack_engine.sv
// Directed bench for attack_engine: frame-by-frame expectations per scenario.
module tb_attack_engine;

  logic               frame_clk = 1'b0;
  logic               Reset_n;
  logic [7:0]         keycode_0, keycode_1, keycode_2, keycode_3;
  logic               crouchP1, crouchP2, P1Left;
  logic signed [31:0] XDist, P1Ypos, P2Ypos;
  logic               activeP1, activeP2, hitP1, hitP2;
  logic               blockP1, blockP2, stunP1, stunP2;
  logic signed [31:0] Ryu_Knockback, Akuma_Knockback;

  int total = 0;
  int bad   = 0;

  always #5 frame_clk = ~frame_clk;

  attack_engine dut (
    .frame_clk       (frame_clk),
    .Reset_n         (Reset_n),
    .keycode_0       (keycode_0),
    .keycode_1       (keycode_1),
    .keycode_2       (keycode_2),
    .keycode_3       (keycode_3),
    .crouchP1        (crouchP1),
    .crouchP2        (crouchP2),
    .P1Left          (P1Left),
    .XDist           (XDist),
    .P1Ypos          (P1Ypos),
    .P2Ypos          (P2Ypos),
    .activeP1        (activeP1),
    .activeP2        (activeP2),
    .hitP1           (hitP1),
    .hitP2           (hitP2),
    .blockP1         (blockP1),
    .blockP2         (blockP2),
    .stunP1          (stunP1),
    .stunP2          (stunP2),
    .Ryu_Knockback   (Ryu_Knockback),
    .Akuma_Knockback (Akuma_Knockback)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one frame and land on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic frame_chk(input string tag, input int f,
                           input logic a1, input logic a2,
                           input logic h1, input logic h2,
                           input logic b1, input logic b2,
                           input logic s1, input logic s2,
                           input int ryu, input int aku);
    chk($sformatf("%s f%0d activeP1", tag, f), activeP1, a1);
    chk($sformatf("%s f%0d activeP2", tag, f), activeP2, a2);
    chk($sformatf("%s f%0d hitP1", tag, f), hitP1, h1);
    chk($sformatf("%s f%0d hitP2", tag, f), hitP2, h2);
    chk($sformatf("%s f%0d blockP1", tag, f), blockP1, b1);
    chk($sformatf("%s f%0d blockP2", tag, f), blockP2, b2);
    chk($sformatf("%s f%0d stunP1", tag, f), stunP1, s1);
    chk($sformatf("%s f%0d stunP2", tag, f), stunP2, s2);
    chk($sformatf("%s f%0d Ryu_Knockback", tag, f), Ryu_Knockback, ryu);
    chk($sformatf("%s f%0d Akuma_Knockback", tag, f), Akuma_Knockback, aku);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n   = 1'b1;
    keycode_0 = 8'h00;
    keycode_1 = 8'h00;
    keycode_2 = 8'h00;
    keycode_3 = 8'h00;
    crouchP1  = 1'b0;
    crouchP2  = 1'b0;
    P1Left    = 1'b1;
    XDist     = 32'sd300;
    P1Ypos    = 32'sd200;
    P2Ypos    = 32'sd200;
    #2 Reset_n = 1'b0;
    #1 frame_chk("in_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    frame_chk("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("txn reset_release checked");

    // Nominal hit: P1 punches P2 in range, P2 standing.
    XDist = 32'sd100;
    keycode_0 = 8'h06;
    for (int f = 1; f <= 17; f++) begin
      tick();
      frame_chk("hit", f, (f >= 3 && f <= 5), 0, 0, (f == 4), 0, 0, 0,
                (f >= 4 && f <= 15), 0, (f >= 4 && f <= 15) ? 4 : 0);
    end
    keycode_0 = 8'h00;
    tick();
    $display("txn nominal_hit frames=17");

    // Block: same attack, P2 crouching; key pressed on keycode_2 slot.
    crouchP2 = 1'b1;
    keycode_2 = 8'h06;
    for (int f = 1; f <= 12; f++) begin
      tick();
      frame_chk("block", f, (f >= 3 && f <= 5), 0, 0, 0, 0, (f == 4), 0,
                (f >= 4 && f <= 9), 0, (f >= 4 && f <= 9) ? 2 : 0);
    end
    keycode_2 = 8'h00;
    crouchP2 = 1'b0;
    tick();
    $display("txn block frames=12");

    // Miss at exactly REACH; presses during RECOVERY are discarded, so the
    // second attack only begins from the press at frame 12.
    XDist = 32'sd135;
    for (int f = 1; f <= 21; f++) begin
      keycode_0 = (f <= 8 || f == 10 || f == 12) ? 8'h06 : 8'h00;
      tick();
      frame_chk("miss", f, ((f >= 3 && f <= 5) || (f >= 14 && f <= 16)), 0,
                0, 0, 0, 0, 0, 0, 0, 0);
    end
    keycode_0 = 8'h00;
    tick();
    $display("txn miss frames=21");

    // Interrupt: P2 starts at frame 3 and is hit in STARTUP; its re-press
    // while stunned is discarded and the held key never retriggers.
    XDist = 32'sd100;
    for (int f = 1; f <= 20; f++) begin
      keycode_0 = 8'h06;
      keycode_1 = ((f >= 3 && f <= 5) || f >= 8) ? 8'h11 : 8'h00;
      tick();
      frame_chk("interrupt", f, (f >= 3 && f <= 5), 0, 0, (f == 4), 0, 0, 0,
                (f >= 4 && f <= 15), 0, (f >= 4 && f <= 15) ? 4 : 0);
    end
    keycode_0 = 8'h00;
    keycode_1 = 8'h00;
    tick();
    $display("txn interrupt frames=20");

    // Trade with P1 on the right: both hit on the same frame, knockback flips.
    P1Left = 1'b0;
    keycode_0 = 8'h06;
    keycode_3 = 8'h11;
    for (int f = 1; f <= 16; f++) begin
      tick();
      frame_chk("trade", f, (f == 3), (f == 3), (f == 4), (f == 4), 0, 0,
                (f >= 4 && f <= 15), (f >= 4 && f <= 15),
                (f >= 4 && f <= 15) ? 4 : 0, (f >= 4 && f <= 15) ? -4 : 0);
    end
    keycode_0 = 8'h00;
    keycode_3 = 8'h00;
    P1Left = 1'b1;
    tick();
    $display("txn trade frames=16");

    // Crouching press is dropped, not queued after the crouch ends.
    XDist = 32'sd300;
    keycode_0 = 8'h06;
    for (int f = 1; f <= 8; f++) begin
      crouchP1 = (f <= 2);
      tick();
      frame_chk("crouch", f, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    keycode_0 = 8'h00;
    tick();
    $display("txn crouch_gate frames=8");

    // Key held for 20 frames gives exactly one attack.
    keycode_0 = 8'h06;
    for (int f = 1; f <= 20; f++) begin
      tick();
      frame_chk("held", f, (f >= 3 && f <= 5), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    keycode_0 = 8'h00;
    tick();
    $display("txn held_key frames=20");

    // Reset during stun clears outputs at once; fresh press works afterwards.
    XDist = 32'sd100;
    keycode_0 = 8'h06;
    for (int f = 1; f <= 6; f++) tick();
    chk("pre_reset stunP2", stunP2, 1);
    chk("pre_reset Akuma_Knockback", Akuma_Knockback, 4);
    keycode_0 = 8'h00;
    Reset_n = 1'b0;
    #1 frame_chk("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      tick();
      frame_chk("post_reset", f, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    keycode_0 = 8'h06;
    for (int f = 1; f <= 5; f++) begin
      tick();
      frame_chk("post_reset_attack", f, (f >= 3 && f <= 5), 0, 0, (f == 4),
                0, 0, 0, (f >= 4), 0, (f >= 4) ? 4 : 0);
    end
    keycode_0 = 8'h00;
    $display("txn reset_mid_stun frames=11");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
